apb_master_ctrl: RTL and testbench

- APB master sequencer and 2-requester arbiter. It sits between two internal request ports and the APB slave bus, with two slaves of 64×8 memory each.
- Round-robin arbitration picks one requester. The block decodes the address to a slave select and runs the SETUP/ACCESS protocol, waiting on PREADY with a timeout.
- It returns read data, or an error, to the winning requester as a one-cycle response pulse.

---
 rtl/apb_ctrl_pkg.sv | 20 ++
 rtl/apb_rr_arbiter.sv | 31 +++
 rtl/apb_master_ctrl.sv | 168 ++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared types and constants for the APB master controller.
//   apb_state_e  - sequencer states (IDLE, SETUP, ACCESS, RESP)
//   DEF_*        - default slave-select bit and ACCESS timeout
//   OFFSET_MASK  - offset bits forwarded to PADDR
//   UNMAPPED_BIT - request address bit flagging an unmapped offset
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int         DEF_SLV_SEL_BIT = 7;
  localparam int         DEF_TIMEOUT     = 16;
  localparam logic [5:0] OFFSET_MASK     = 6'h3F;
  localparam int         UNMAPPED_BIT    = 6;

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: two-way round-robin arbiter.
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   req_i[1:0]    - request vector
//   grant_en_i    - arbitration allowed this cycle
//   grant_o[1:0]  - one-hot grant (zero when disabled or no request)
module apb_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] grant_o
);

  // 1 = requester 1 has priority on a tie; reset favours requester 0.
  logic prio_q;

  always_comb begin
    grant_o = 2'b00;
    if (grant_en_i) begin
      if (req_i == 2'b11) grant_o = prio_q ? 2'b10 : 2'b01;
      else                grant_o = req_i;
    end
  end

  // Priority moves to the requester that was not just served.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      prio_q <= 1'b0;
    else if (grant_en_i && |req_i)  prio_q <= grant_o[0];
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB master sequencer with a 2-requester round-robin front end.
//   PCLK, PRESET          - clock, asynchronous active-high reset
//   req_valid/write/addr/wdata - per-requester request (requester n uses slice n)
//   req_accept            - one-cycle pulse when a request is latched
//   rsp_valid/rdata/err   - one-cycle completion pulse with read data / error
//   PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA - APB master outputs
//   PRDATA1/2, PREADY1/2  - per-slave APB returns
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SLV_SEL_BIT = DEF_SLV_SEL_BIT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_accept,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL1,
  output logic                PSEL2,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA1,
  input  logic [DATA_W-1:0]   PRDATA2,
  input  logic                PREADY1,
  input  logic                PREADY2
);

  localparam int                CNT_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK_W = ADDR_W'(OFFSET_MASK);

  apb_state_e          state_q;
  logic                winner_q;
  logic                slv_q;        // 0 = slave 1, 1 = slave 2
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          req_accept_q;
  logic [1:0]          rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                psel1_q, psel2_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;

  logic [1:0]          grant_d;
  logic                win_d;
  logic                wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                pready_d;
  logic [DATA_W-1:0]   prdata_d;

  logic [ADDR_W-1:0]   req_addr_a  [2];
  logic [DATA_W-1:0]   req_wdata_a [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign req_addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign req_wdata_a[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  apb_rr_arbiter u_arb (
    .clk_i      (PCLK),
    .rst_i      (PRESET),
    .req_i      (req_valid),
    .grant_en_i (state_q == IDLE),
    .grant_o    (grant_d)
  );

  assign win_d   = grant_d[1];
  assign wr_d    = req_write[win_d];
  assign addr_d  = req_addr_a[win_d];
  assign wdata_d = req_wdata_a[win_d];

  // Only the selected slave's handshake is looked at.
  assign pready_d = slv_q ? PREADY2 : PREADY1;
  assign prdata_d = slv_q ? PRDATA2 : PRDATA1;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      winner_q     <= 1'b0;
      slv_q        <= 1'b0;
      cnt_q        <= '0;
      req_accept_q <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      psel1_q      <= 1'b0;
      psel2_q      <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      // Pulses last a single cycle; response data is zero outside RESP.
      req_accept_q <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant_d) begin
            winner_q     <= win_d;
            req_accept_q <= grant_d;
            if (addr_d[UNMAPPED_BIT]) begin
              // Unmapped offset: answer straight away, bus stays quiet.
              rsp_valid_q <= grant_d;
              rsp_err_q   <= 1'b1;
              state_q     <= RESP;
            end else begin
              slv_q    <= addr_d[SLV_SEL_BIT];
              psel1_q  <= ~addr_d[SLV_SEL_BIT];
              psel2_q  <= addr_d[SLV_SEL_BIT];
              paddr_q  <= addr_d & OFFSET_MASK_W;
              pwrite_q <= wr_d;
              pwdata_q <= wdata_d;
              state_q  <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A ready on the last allowed cycle still completes normally.
          if (pready_d || (cnt_q == CNT_LAST)) begin
            rsp_valid_q <= {winner_q, ~winner_q};
            rsp_err_q   <= ~pready_d;
            rsp_rdata_q <= (pready_d && !pwrite_q) ? prdata_d : '0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_accept = req_accept_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign PSEL1      = psel1_q;
  assign PSEL2      = psel2_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: scoreboard bench for apb_master_ctrl with two 64x8 slave models.
module tb_apb_master_ctrl;

  localparam int TMO = 16;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_accept;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0]  PADDR, PWDATA;
  logic [7:0]  PRDATA1, PRDATA2;
  logic        PREADY1, PREADY2;

  bit          rdy1, rdy2;
  logic [7:0]  mem1 [64];
  logic [7:0]  mem2 [64];
  logic [7:0]  ref_mem [2][64];
  logic [10:0] exp_q [$];
  int          n_cmp, n_mis;
  logic [32:0] all_outs;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .SLV_SEL_BIT(7), .TIMEOUT(TMO)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_accept (req_accept),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .PSEL1      (PSEL1),
    .PSEL2      (PSEL2),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA1    (PRDATA1),
    .PRDATA2    (PRDATA2),
    .PREADY1    (PREADY1),
    .PREADY2    (PREADY2)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign all_outs = {req_accept, rsp_valid, rsp_rdata, rsp_err, PSEL1, PSEL2,
                     PENABLE, PWRITE, PADDR, PWDATA};

  // Slave models: zero-wait unless their ready is held low.
  assign PREADY1 = rdy1;
  assign PREADY2 = rdy2;
  always_comb begin
    PRDATA1 = mem1[PADDR[5:0]];
    PRDATA2 = mem2[PADDR[5:0]];
  end
  always @(posedge PCLK) begin
    if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR[5:0]] <= PWDATA;
    if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR[5:0]] <= PWDATA;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every response pulse pops one expectation.
  always @(negedge PCLK) begin
    if (!PRESET && (|rsp_valid)) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(e));
      end
      $display("rsp valid=%b rdata=%h err=%0d", rsp_valid, rsp_rdata, rsp_err);
    end
  end

  // One transfer from requester n, with bus-protocol and latency checks.
  task automatic xfer(input int n, input bit w, input logic [7:0] a, input logic [7:0] d);
    bit         unm, slv, tmo, err, got;
    logic [7:0] rd;
    logic [7:0] exp_paddr;
    int         exp_lat, exp_en, exp_sel, lat, sel_ok, sel_bad, en_cnt, bus_bad;
    unm       = a[6];
    slv       = a[7];
    tmo       = !unm && (slv ? !rdy2 : !rdy1);
    err       = unm || tmo;
    rd        = (err || w) ? 8'h00 : ref_mem[slv][a[5:0]];
    if (w && !err) ref_mem[slv][a[5:0]] = d;
    exp_lat   = unm ? 1 : (tmo ? TMO + 2 : 3);
    exp_en    = unm ? 0 : (tmo ? TMO : 1);
    exp_sel   = unm ? 0 : exp_en + 1;
    exp_paddr = {2'b00, a[5:0]};
    exp_q.push_back({(n == 1) ? 2'b10 : 2'b01, err, rd});

    @(negedge PCLK);
    req_valid[n]       = 1'b1;
    req_write[n]       = w;
    req_addr[n*8 +: 8]  = a;
    req_wdata[n*8 +: 8] = d;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("accept", 64'(req_accept), 64'((n == 1) ? 2'b10 : 2'b01));
    req_valid[n] = 1'b0;

    lat = 1; got = 0; sel_ok = 0; sel_bad = 0; en_cnt = 0; bus_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (|rsp_valid) begin
        got = 1;
        break;
      end
      if (slv ? PSEL2 : PSEL1) sel_ok++;
      if (slv ? PSEL1 : PSEL2) sel_bad++;
      if (PENABLE) en_cnt++;
      if ((PSEL1 || PSEL2) && ({PADDR, PWRITE, PWDATA} !== {exp_paddr, w, d})) bus_bad++;
      @(negedge PCLK);
      lat++;
    end
    chk("rsp_seen", 64'(got), 64'(1));
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("psel_cycles", 64'(sel_ok), 64'(exp_sel));
    chk("psel_other", 64'(sel_bad), 64'(0));
    chk("penable_cycles", 64'(en_cnt), 64'(exp_en));
    chk("bus_fields", 64'(bus_bad), 64'(0));
    chk("bus_idle_at_rsp", 64'({PSEL1, PSEL2, PENABLE}), 64'(0));
  endtask

  initial begin
    repeat (20000) @(posedge PCLK);
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  idx;
    bit  seen;
    logic [1:0] arb_exp [4];
    n_cmp = 0; n_mis = 0;
    PRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rdy1 = 1'b1; rdy2 = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("reset_outputs", 64'(all_outs), 64'(0));
    PRESET = 1'b0;

    // Slave 1 write then read back.
    xfer(0, 1'b1, 8'h05, 8'hA5);
    xfer(0, 1'b0, 8'h05, 8'h00);

    // Slave 2; slave 1's ready held low must not matter.
    rdy1 = 1'b0;
    xfer(1, 1'b1, 8'h83, 8'h3C);
    xfer(1, 1'b0, 8'h83, 8'h00);
    rdy1 = 1'b1;

    // Both requesting continuously: grants alternate starting at req0.
    arb_exp[0] = 2'b01; arb_exp[1] = 2'b10; arb_exp[2] = 2'b01; arb_exp[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        ref_mem[0][6'h10] = 8'h11;
        exp_q.push_back({2'b01, 1'b0, 8'h00});
      end else begin
        ref_mem[1][6'h10] = 8'h22;
        exp_q.push_back({2'b10, 1'b0, 8'h00});
      end
    end
    @(negedge PCLK);
    req_valid = 2'b11; req_write = 2'b11;
    req_addr  = {8'h90, 8'h10};
    req_wdata = {8'h22, 8'h11};
    idx = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge PCLK);
      if (|req_accept) begin
        chk("arb_grant", 64'(req_accept), 64'(arb_exp[idx]));
        idx++;
        if (idx == 4) begin
          req_valid = 2'b00;
          break;
        end
      end
    end
    chk("arb_grant_count", 64'(idx), 64'(4));
    repeat (6) @(negedge PCLK);
    xfer(1, 1'b0, 8'h90, 8'h00);
    xfer(0, 1'b0, 8'h10, 8'h00);

    // Timeout on slave 1 while slave 2 reports ready.
    rdy1 = 1'b0;
    xfer(0, 1'b0, 8'h07, 8'h00);
    rdy1 = 1'b1;

    // Unmapped offsets from each requester.
    xfer(0, 1'b1, 8'h40, 8'hFF);
    xfer(1, 1'b0, 8'hC0, 8'h00);

    // Reset while in ACCESS: transfer dropped silently.
    rdy1 = 1'b0;
    @(negedge PCLK);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[7:0] = 8'h05;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (req_accept[0]) req_valid[0] = 1'b0;
      if (PENABLE) begin
        seen = 1;
        break;
      end
    end
    chk("reached_access", 64'(seen), 64'(1));
    PRESET = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("reset_mid_outputs", 64'(all_outs), 64'(0));
    repeat (3) @(negedge PCLK);
    chk("reset_hold_outputs", 64'(all_outs), 64'(0));
    PRESET = 1'b0;
    rdy1 = 1'b1;
    xfer(1, 1'b0, 8'h05, 8'h00);

    repeat (4) @(negedge PCLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
